vram_writer: RTL and testbench
==============================

VRAM_WRITER -- requirements
Module: vram_writer

Interface
REQ-001 Parameter FB_WIDTH, 160, framebuffer width in pixels.
REQ-002 Parameter FB_HEIGHT, 120, framebuffer height in pixels.
REQ-003 Parameter FIFO_DEPTH, 4, write-request FIFO entries (power of two).
REQ-004 clock_25mhz  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 wr_valid  input  1  pixel write request valid.
REQ-007 wr_ready  output  1  block can accept a pixel write this cycle.
REQ-008 wr_x  input  8  pixel column, 0..FB_WIDTH-1 legal.
REQ-009 wr_y  input  7  pixel row, 0..FB_HEIGHT-1 legal.
REQ-010 wr_color  input  8  pixel colour, RRRGGGBB.
REQ-011 fill_start  input  1  single-cycle request to fill the whole framebuffer.
REQ-012 fill_color  input  8  fill colour, sampled with an accepted fill_start.
REQ-013 busy  output  1  FIFO non-empty, fill pending or fill in progress.
REQ-014 drop_count  output  8  saturating count of discarded out-of-range writes.
REQ-015 vram_we  output  1  write strobe to the VRAM write port, registered.
REQ-016 vram_waddr  output  15  VRAM write address, registered.
REQ-017 vram_wdata  output  8  VRAM write data, registered.

Function
REQ-018 A pixel write SHALL be accepted in any cycle where wr_valid=1 and wr_ready=1.
REQ-019 wr_ready SHALL be 1 exactly when the FIFO is not full, no fill is pending and the state is not FILL.
REQ-020 An accepted write with wr_x>=FB_WIDTH or wr_y>=FB_HEIGHT SHALL NOT enter the FIFO and SHALL increment drop_count, which holds at 255.
REQ-021 An accepted in-range write SHALL be pushed into the FIFO as {addr = wr_y*FB_WIDTH + wr_x (15 bits, exact), color}.
REQ-022 The FSM SHALL have states IDLE, DRAIN and FILL.
REQ-023 IDLE->DRAIN when the FIFO is non-empty; DRAIN pops one entry per cycle; DRAIN->IDLE when the FIFO becomes empty; if a push and a pop occur in the same cycle, both SHALL take effect.
REQ-024 A popped entry SHALL appear on vram_waddr/vram_wdata with vram_we=1 in the cycle after the pop; vram_we SHALL be 0 in every cycle with no write.
REQ-025 Latency SHALL be exactly 2 cycles from acceptance (cycle k) to vram_we=1 (cycle k+2) when the FIFO was empty and no fill was pending; sustained throughput SHALL be one write per cycle.
REQ-026 fill_start SHALL be accepted only when no fill is pending and the state is not FILL; otherwise it SHALL be ignored and fill_color discarded.
REQ-027 An accepted fill_start SHALL latch fill_color and set fill_pending; a pixel write accepted in the same cycle SHALL be enqueued and written before the fill.
REQ-028 With fill_pending set and the FIFO empty, the FSM SHALL enter FILL, clear fill_pending, and write addresses 0 through FB_WIDTH*FB_HEIGHT-1 (0..19199) in ascending order, one per consecutive cycle, with data equal to the latched colour.
REQ-029 After address 19199 the FSM SHALL return to IDLE with no gap cycle and no extra write; vram_waddr SHALL never exceed 19199.
REQ-030 busy SHALL be 1 from the cycle after an accepted write or fill_start until the cycle after the last vram_we of that work.

Reset
REQ-031 While reset=1: state IDLE, FIFO empty, fill_pending=0, busy=0, drop_count=0, vram_we=0, vram_waddr=0, vram_wdata=0.
REQ-032 Reset asserted mid-fill or mid-drain SHALL abort immediately, with no further vram_we and FIFO contents discarded.
REQ-033 wr_ready SHALL be 1 in the first cycle after reset deassertion.

Verification
REQ-034 Single write (x=5, y=2, color=0xE3) into an idle block at cycle k -> vram_we=1, waddr=325, wdata=0xE3 at k+2 only.
REQ-035 Back-to-back writes with wr_valid held and 4 requests (x=0..3, y=0) -> four consecutive vram_we cycles, addresses 0..3; wr_ready stays 1 throughout.
REQ-036 Writes x=160 and y=120 -> no vram_we, drop_count=2; 256 further bad writes -> drop_count=255.
REQ-037 Two queued writes plus fill_start (color=0x1C) in the same cycle -> both writes first, then exactly 19200 consecutive writes of 0x1C at addresses 0..19199; wr_ready=0 until the fill ends.
REQ-038 Reset pulse at fill address 1000 -> vram_we=0 from the reset onward, busy=0, drop_count=0; a new fill afterwards restarts at address 0.
REQ-039 Fill FIFO with 4 writes while stalled behind a fill -> wr_ready=0; second fill_start during FILL ignored; exactly one 19200-write pass.

Source files
------------

// File: rtl/vram_writer_if.sv
// -----------------------------------------------------------------------------
// vram_writer_if
// Bundles the pixel-write handshake, fill request, status and VRAM write-port
// signals of vram_writer.
//   master : request side (drives wr_*, fill_*; observes ready/status/VRAM port)
//   slave  : the vram_writer itself
// Signals:
//   wr_valid/wr_ready       pixel write handshake
//   wr_x[7:0], wr_y[6:0]    pixel coordinates
//   wr_color[7:0]           pixel colour, RRRGGGBB
//   fill_start, fill_color  whole-framebuffer fill request and its colour
//   busy, drop_count[7:0]   status
//   vram_we, vram_waddr[14:0], vram_wdata[7:0]  registered VRAM write port
// -----------------------------------------------------------------------------
interface vram_writer_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_x;
    logic [6:0]  wr_y;
    logic [7:0]  wr_color;
    logic        fill_start;
    logic [7:0]  fill_color;
    logic        busy;
    logic [7:0]  drop_count;
    logic        vram_we;
    logic [14:0] vram_waddr;
    logic [7:0]  vram_wdata;

    modport master (
        output wr_valid, wr_x, wr_y, wr_color, fill_start, fill_color,
        input  wr_ready, busy, drop_count, vram_we, vram_waddr, vram_wdata
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_color, fill_start, fill_color,
        output wr_ready, busy, drop_count, vram_we, vram_waddr, vram_wdata
    );
endinterface

// File: rtl/vram_writer.sv
// -----------------------------------------------------------------------------
// vram_writer
// Queues pixel writes in a small FIFO and streams them to a VRAM write port,
// one per cycle. A fill request paints the whole framebuffer with one colour
// after all writes queued ahead of it have been written.
// Ports:
//   clock_25mhz  sole clock, rising edge
//   reset        asynchronous, active-high
//   bus          vram_writer_if.slave (handshake, fill, status, VRAM port)
// -----------------------------------------------------------------------------
module vram_writer #(
    parameter int unsigned FB_WIDTH   = 160,
    parameter int unsigned FB_HEIGHT  = 120,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         clock_25mhz,
    input  logic         reset,
    vram_writer_if.slave bus
);
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [14:0] LAST_ADDR = 15'(FB_WIDTH * FB_HEIGHT - 1);

    typedef enum logic [1:0] {StIdle, StDrain, StFill} state_e;

    state_e         r_state, w_state_d;
    logic [PTR_W:0] r_wptr, r_rptr, w_wptr_d, w_rptr_d;
    logic [14:0]    r_fifo_addr  [FIFO_DEPTH];
    logic [7:0]     r_fifo_color [FIFO_DEPTH];
    logic           r_fill_pending, w_fill_pending_d;
    logic [7:0]     r_fill_color;
    logic [14:0]    r_fill_addr, w_fill_addr_d;
    logic [7:0]     r_drop_count;
    logic           r_vram_we;
    logic [14:0]    r_vram_waddr;
    logic [7:0]     r_vram_wdata;

    logic           w_empty, w_full, w_wr_ready, w_wr_accept, w_in_range;
    logic           w_push, w_drop, w_fill_accept, w_pop;
    logic [14:0]    w_push_addr;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);

    assign w_wr_ready    = !w_full && !r_fill_pending && (r_state != StFill);
    assign w_wr_accept   = bus.wr_valid && w_wr_ready;
    assign w_in_range    = (32'(bus.wr_x) < FB_WIDTH) && (32'(bus.wr_y) < FB_HEIGHT);
    assign w_push        = w_wr_accept && w_in_range;
    assign w_drop        = w_wr_accept && !w_in_range;
    assign w_fill_accept = bus.fill_start && !r_fill_pending && (r_state != StFill);
    assign w_push_addr   = 15'(bus.wr_y) * 15'(FB_WIDTH) + 15'(bus.wr_x);

    // Popping also happens in idle so a write into an empty block reaches the
    // VRAM port two cycles after acceptance.
    assign w_pop = (r_state != StFill) && !w_empty;

    assign w_wptr_d = r_wptr + {{PTR_W{1'b0}}, w_push};
    assign w_rptr_d = r_rptr + {{PTR_W{1'b0}}, w_pop};

    always_comb begin
        w_state_d        = r_state;
        w_fill_pending_d = r_fill_pending;
        w_fill_addr_d    = r_fill_addr;
        if (w_fill_accept) begin
            w_fill_pending_d = 1'b1;
        end
        case (r_state)
            StIdle, StDrain: begin
                if (w_wptr_d != w_rptr_d) begin
                    w_state_d = StDrain;
                end else if (r_fill_pending) begin
                    // Queue drains this cycle: start the fill with no gap.
                    w_state_d        = StFill;
                    w_fill_pending_d = 1'b0;
                    w_fill_addr_d    = '0;
                end else begin
                    w_state_d = StIdle;
                end
            end
            StFill: begin
                if (r_fill_addr == LAST_ADDR) begin
                    w_state_d     = StIdle;
                    w_fill_addr_d = '0;
                end else begin
                    w_fill_addr_d = r_fill_addr + 15'd1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_25mhz or posedge reset) begin
        if (reset) begin
            r_state        <= StIdle;
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_fill_pending <= 1'b0;
            r_fill_color   <= '0;
            r_fill_addr    <= '0;
            r_drop_count   <= '0;
            r_vram_we      <= 1'b0;
            r_vram_waddr   <= '0;
            r_vram_wdata   <= '0;
        end else begin
            r_state        <= w_state_d;
            r_wptr         <= w_wptr_d;
            r_rptr         <= w_rptr_d;
            r_fill_pending <= w_fill_pending_d;
            r_fill_addr    <= w_fill_addr_d;
            if (w_fill_accept) begin
                r_fill_color <= bus.fill_color;
            end
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
            r_vram_we <= w_pop || (r_state == StFill);
            if (w_pop) begin
                r_vram_waddr <= r_fifo_addr[r_rptr[PTR_W-1:0]];
                r_vram_wdata <= r_fifo_color[r_rptr[PTR_W-1:0]];
            end else if (r_state == StFill) begin
                r_vram_waddr <= r_fill_addr;
                r_vram_wdata <= r_fill_color;
            end
        end
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clock_25mhz) begin
        if (w_push) begin
            r_fifo_addr[r_wptr[PTR_W-1:0]]  <= w_push_addr;
            r_fifo_color[r_wptr[PTR_W-1:0]] <= bus.wr_color;
        end
    end

    assign bus.wr_ready   = w_wr_ready;
    assign bus.busy       = !w_empty || r_fill_pending || (r_state == StFill) || r_vram_we;
    assign bus.drop_count = r_drop_count;
    assign bus.vram_we    = r_vram_we;
    assign bus.vram_waddr = r_vram_waddr;
    assign bus.vram_wdata = r_vram_wdata;
endmodule

// File: tb/tb_vram_writer.sv
// -----------------------------------------------------------------------------
// tb_vram_writer
// Self-checking bench for vram_writer. Pixel writes are compared against a
// reference queue of {address, colour, due cycle} built from the framebuffer
// arithmetic; fills are checked as one ascending pass over every address.
// -----------------------------------------------------------------------------
module tb_vram_writer;
    localparam int W    = 160;
    localparam int H    = 120;
    localparam int NPIX = W * H;

    logic clock_25mhz = 1'b0;
    logic reset;

    vram_writer_if bus ();

    vram_writer #(
        .FB_WIDTH  (W),
        .FB_HEIGHT (H),
        .FIFO_DEPTH(4)
    ) dut (
        .clock_25mhz(clock_25mhz),
        .reset      (reset),
        .bus        (bus)
    );

    always #20 clock_25mhz = ~clock_25mhz;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int m_drop   = 0;
    int q_addr[$];
    int q_data[$];
    int q_due[$];

    task automatic tick();
        @(posedge clock_25mhz);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_checks++;
        assert (obs === 32'(exp)) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.wr_valid   = 1'b0;
        bus.wr_x       = '0;
        bus.wr_y       = '0;
        bus.wr_color   = '0;
        bus.fill_start = 1'b0;
        bus.fill_color = '0;
    endtask

    task automatic clear_model();
        q_addr.delete();
        q_data.delete();
        q_due.delete();
        m_drop = 0;
    endtask

    // One cycle with no fill involved: check outputs against the model, then
    // present an optional write. An empty block writes exactly 2 cycles later.
    task automatic run_cycle(input bit v, input int x, input int y, input int col);
        bit exp_we;
        chk("ready", 32'(bus.wr_ready), 1);
        chk("busy", 32'(bus.busy), (q_due.size() != 0) ? 1 : 0);
        chk("drop", 32'(bus.drop_count), m_drop);
        exp_we = (q_due.size() != 0) && (q_due[0] == cyc);
        chk("we", 32'(bus.vram_we), exp_we ? 1 : 0);
        if (exp_we) begin
            chk("addr", 32'(bus.vram_waddr), q_addr.pop_front());
            chk("data", 32'(bus.vram_wdata), q_data.pop_front());
            void'(q_due.pop_front());
        end
        bus.wr_valid   = v;
        bus.wr_x       = 8'(x);
        bus.wr_y       = 7'(y);
        bus.wr_color   = 8'(col);
        bus.fill_start = 1'b0;
        if (v) begin
            if (x < W && y < H) begin
                q_addr.push_back(y * W + x);
                q_data.push_back(col);
                q_due.push_back(cyc + 2);
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
        tick();
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 0, 0, 0);
    endtask

    task automatic random_burst(input int n);
        for (int i = 0; i < n; i++) begin
            run_cycle(($urandom_range(0, 9) < 7), int'($urandom_range(0, 170)),
                      int'($urandom_range(0, 127)), int'($urandom_range(0, 255)));
        end
        settle(4);
    endtask

    // Expect one complete fill pass of colour col, starting within a few
    // cycles. With poke set, writes and a second fill are attempted mid-fill.
    task automatic fill_pass(input logic [7:0] col, input bit poke);
        int waited = 0;
        int nbad   = 0;
        int nextra = 0;
        while (bus.vram_we !== 1'b1 && waited < 8) begin
            if (bus.wr_ready !== 1'b0) nbad++;
            tick();
            waited++;
        end
        chk("fill_first_we", 32'(bus.vram_we), 1);
        for (int i = 0; i < NPIX; i++) begin
            if (bus.vram_we !== 1'b1 || bus.vram_waddr !== 15'(i) ||
                bus.vram_wdata !== col || bus.busy !== 1'b1) nbad++;
            if (i < NPIX - 1 && bus.wr_ready !== 1'b0) nbad++;
            if (poke) begin
                bus.wr_valid   = (i >= 10 && i < 14);
                bus.wr_x       = 8'(i);
                bus.wr_y       = 7'd1;
                bus.wr_color   = 8'hEE;
                bus.fill_start = (i == 20 || i == 21);
                bus.fill_color = 8'hFF;
            end
            tick();
        end
        idle_inputs();
        chk("fill_pass_errs", 32'(nbad), 0);
        chk("post_fill_we", 32'(bus.vram_we), 0);
        chk("post_fill_busy", 32'(bus.busy), 0);
        chk("post_fill_ready", 32'(bus.wr_ready), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.vram_we !== 1'b0) nextra++;
        end
        chk("post_fill_extra_we", 32'(nextra), 0);
    endtask

    initial begin
        int n;
        idle_inputs();
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_we", 32'(bus.vram_we), 0);
        chk("rst_waddr", 32'(bus.vram_waddr), 0);
        chk("rst_wdata", 32'(bus.vram_wdata), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_drop", 32'(bus.drop_count), 0);
        reset = 1'b0;
        chk("ready_after_reset", 32'(bus.wr_ready), 1);

        // Single write: address 2*160+5 = 325 two cycles later, nothing else.
        run_cycle(1'b1, 5, 2, 'hE3);
        settle(4);

        // Four back-to-back writes on row 0.
        for (int i = 0; i < 4; i++) run_cycle(1'b1, i, 0, 'h40 + i);
        settle(5);

        // Out-of-range writes: counted, never written, saturating at 255.
        run_cycle(1'b1, 160, 0, 'h11);
        run_cycle(1'b1, 0, 120, 'h22);
        settle(2);
        chk("drop_two", 32'(bus.drop_count), 2);
        for (int i = 0; i < 256; i++) run_cycle(1'b1, 160 + (i % 96), i % 128, i);
        settle(2);
        chk("drop_sat", 32'(bus.drop_count), 255);

        random_burst(300);

        // Two writes, the second alongside fill_start: writes first, then fill.
        chk("f_ready0", 32'(bus.wr_ready), 1);
        bus.wr_valid = 1'b1; bus.wr_x = 8'd10; bus.wr_y = 7'd3; bus.wr_color = 8'hA5;
        tick();
        chk("f_ready1", 32'(bus.wr_ready), 1);
        chk("f_busy1", 32'(bus.busy), 1);
        bus.wr_x = 8'd11; bus.wr_color = 8'h5A;
        bus.fill_start = 1'b1; bus.fill_color = 8'h1C;
        tick();
        idle_inputs();
        bus.wr_valid = 1'b1; bus.wr_x = 8'd20; bus.wr_y = 7'd5; bus.wr_color = 8'h77;
        chk("f_w0_we", 32'(bus.vram_we), 1);
        chk("f_w0_addr", 32'(bus.vram_waddr), 3 * W + 10);
        chk("f_w0_data", 32'(bus.vram_wdata), 'hA5);
        chk("f_w0_ready", 32'(bus.wr_ready), 0);
        tick();
        chk("f_w1_we", 32'(bus.vram_we), 1);
        chk("f_w1_addr", 32'(bus.vram_waddr), 3 * W + 11);
        chk("f_w1_data", 32'(bus.vram_wdata), 'h5A);
        chk("f_w1_ready", 32'(bus.wr_ready), 0);
        idle_inputs();
        tick();
        fill_pass(8'h1C, 1'b0);

        // Reset in the middle of a fill.
        chk("r_ready", 32'(bus.wr_ready), 1);
        bus.fill_start = 1'b1; bus.fill_color = 8'h3C;
        tick();
        idle_inputs();
        n = 0;
        while (!(bus.vram_we === 1'b1 && bus.vram_waddr === 15'd1000) && n < 1500) begin
            tick();
            n++;
        end
        chk("reach_addr_1000", 32'(bus.vram_we === 1'b1 && bus.vram_waddr === 15'd1000), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_we", 32'(bus.vram_we), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_drop", 32'(bus.drop_count), 0);
        chk("mid_rst_waddr", 32'(bus.vram_waddr), 0);
        tick();
        chk("mid_rst_we_held", 32'(bus.vram_we), 0);
        reset = 1'b0;
        chk("mid_rst_ready", 32'(bus.wr_ready), 1);
        tick();
        chk("after_rst_we", 32'(bus.vram_we), 0);
        chk("after_rst_busy", 32'(bus.busy), 0);
        clear_model();

        // New fill restarts at 0; writes and a second fill_start are refused.
        bus.fill_start = 1'b1; bus.fill_color = 8'hC3;
        tick();
        idle_inputs();
        fill_pass(8'hC3, 1'b1);

        random_burst(150);

        // Reset while a write is queued: it must never reach the VRAM port.
        run_cycle(1'b1, 7, 7, 'h99);
        idle_inputs();
        reset = 1'b1;
        #1;
        chk("drain_rst_we", 32'(bus.vram_we), 0);
        tick();
        reset = 1'b0;
        clear_model();
        settle(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
